// File: rtl/aer_pkg.sv
// Shared widths, event types and entry-width helper for the AER input buffer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package aer_pkg;

  localparam int AER_ADDR_W = 10;
  localparam int AER_TS_W   = 16;
  localparam int AER_DEPTH  = 8;

  typedef logic [AER_ADDR_W-1:0] aer_addr_t;
  typedef logic [AER_TS_W-1:0]   aer_ts_t;

  typedef struct packed {
    aer_addr_t addr;
    aer_ts_t   ts;
  } aer_event_t;

  // Stored entry width: the timestamp is appended only when the feature is built in.
  function automatic int aer_entry_width(int addr_w, int ts_w, bit ts_en);
    return ts_en ? (addr_w + ts_w) : addr_w;
  endfunction

endpackage

// File: rtl/aer_in_event_buffer_if.sv
// Bus bundle between the AER receive handshake, the event buffer and the core.
// Latency: none (wires only).
// Backpressure: data_required toward upstream, out_ready from the core.
// Optional out_ts signal exists only when AER_IN_TIMESTAMP_EN is defined.
interface aer_in_event_buffer_if
  import aer_pkg::*;
#(
  parameter int ADDR_W = AER_ADDR_W,
  parameter int DEPTH  = AER_DEPTH
`ifdef AER_IN_TIMESTAMP_EN
  , parameter int TS_W = AER_TS_W
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] in_data;
  logic              data_available;
  logic              data_required;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
`ifdef AER_IN_TIMESTAMP_EN
  logic [TS_W-1:0]   out_ts;
`endif
  logic [CNT_W-1:0]  fifo_count;

  // Buffer side.
  modport slave (
    input  in_data, data_available, out_ready,
    output data_required, out_valid, out_addr, fifo_count
`ifdef AER_IN_TIMESTAMP_EN
    , output out_ts
`endif
  );

  // Environment side: upstream handshake plus consuming core.
  modport master (
    output in_data, data_available, out_ready,
    input  data_required, out_valid, out_addr, fifo_count
`ifdef AER_IN_TIMESTAMP_EN
    , input out_ts
`endif
  );

endinterface

// File: rtl/aer_event_fifo_mem.sv
// DEPTH x WIDTH register array with one write port and an asynchronous read port.
// Latency: write lands on the clock edge; read data is combinational from raddr.
// Backpressure: none; the owner decides when we is asserted.
module aer_event_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; validity is tracked by the owner's count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/aer_in_event_buffer.sv
// Captures AER address words from the receive handshake into a first-word fall-through FIFO.
// Latency: a word written on edge N is on out_addr after edge N (one cycle), no bypass.
// Backpressure: data_required drops when full (from registered count only); core stalls via out_ready.
// Optional AER_IN_TIMESTAMP_EN: free-running TS_W counter stamped into each entry, shown on out_ts.
module aer_in_event_buffer
  import aer_pkg::*;
#(
  parameter int ADDR_W = AER_ADDR_W,
  parameter int DEPTH  = AER_DEPTH,
  parameter int TS_W   = AER_TS_W
) (
  input logic                  clk,
  input logic                  rst,
  aer_in_event_buffer_if.slave bus
);

`ifdef AER_IN_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = aer_entry_width(ADDR_W, TS_W, TS_EN);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               has_space;
  logic               has_data;
  logic               wr;
  logic               rd;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;

  // Full/empty come from count alone, so out_ready never reaches data_required.
  assign has_space = (count != FULL_CNT);
  assign has_data  = (count != '0);
  // A strobe while full is a protocol violation and is simply dropped.
  assign wr        = bus.data_available && has_space;
  assign rd        = has_data && bus.out_ready;

  assign bus.data_required = has_space;
  assign bus.out_valid     = has_data;
  assign bus.fifo_count    = count;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr, rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  aer_event_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

`ifdef AER_IN_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  // Free-running timestamp; each write stores the value from before this edge's increment.
  always_ff @(posedge clk) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + TS_W'(1);
  end

  assign wdata        = {bus.in_data, ts_cnt};
  // Stale storage is masked while empty so outputs read zero after reset.
  assign bus.out_addr = has_data ? rdata[ENTRY_W-1 -: ADDR_W] : '0;
  assign bus.out_ts   = has_data ? rdata[TS_W-1:0] : '0;
`else
  assign wdata        = bus.in_data;
  // Stale storage is masked while empty so outputs read zero after reset.
  assign bus.out_addr = has_data ? rdata : '0;
`endif

endmodule

// File: tb/tb_aer_in_event_buffer.sv
// Directed bench for aer_in_event_buffer: reset, fall-through, full/backpressure, wrap, flush, timestamps.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Timestamp vectors run only when AER_IN_TIMESTAMP_EN is defined.
module tb_aer_in_event_buffer;
  import aer_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 8;
  localparam int TS_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

`ifdef AER_IN_TIMESTAMP_EN
  aer_in_event_buffer_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TS_W(TS_W)) bus ();
`else
  aer_in_event_buffer_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();
`endif

  aer_in_event_buffer #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .TS_W   (TS_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_one(input aer_addr_t a);
    bus.in_data        = a;
    bus.data_available = 1'b1;
    tick();
    bus.data_available = 1'b0;
  endtask

  initial begin
    bus.in_data        = '0;
    bus.data_available = 1'b0;
    bus.out_ready      = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_req",   32'(bus.data_required), 32'd1);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_addr",  32'(bus.out_addr), 32'd0);

    // Single write: visible one cycle after the write edge
    write_one(10'h2A5);
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_addr",  32'(bus.out_addr), 32'h2A5);
    check("t1_count", 32'(bus.fifo_count), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t1_drain_count", 32'(bus.fifo_count), 32'd0);
    check("t1_drain_valid", 32'(bus.out_valid), 32'd0);

    // Fill to full with out_ready low
    for (int i = 1; i <= 8; i++) begin
      bus.in_data        = ADDR_W'(i);
      bus.data_available = 1'b1;
      tick();
    end
    check("t2_full_req",   32'(bus.data_required), 32'd0);
    check("t2_full_count", 32'(bus.fifo_count), 32'd8);
    // Strobe held while full must be ignored
    bus.in_data = 10'h3FF;
    tick();
    tick();
    bus.data_available = 1'b0;
    check("t2_ovf_count", 32'(bus.fifo_count), 32'd8);
    check("t2_ovf_head",  32'(bus.out_addr), 32'h001);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("t2_drain_addr", 32'(bus.out_addr), 32'(i));
      tick();
    end
    bus.out_ready = 1'b0;
    check("t2_empty_count", 32'(bus.fifo_count), 32'd0);
    check("t2_empty_req",   32'(bus.data_required), 32'd1);

    // At full: write attempt and read in the same cycle
    for (int i = 0; i < 8; i++) write_one(ADDR_W'(10'h010 + i));
    check("t3_full_count", 32'(bus.fifo_count), 32'd8);
    bus.in_data        = 10'h3EE;
    bus.data_available = 1'b1;
    bus.out_ready      = 1'b1;
    tick();
    bus.data_available = 1'b0;
    bus.out_ready      = 1'b0;
    check("t3_count", 32'(bus.fifo_count), 32'd7);
    check("t3_req",   32'(bus.data_required), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("t3_drain_addr", 32'(bus.out_addr), 32'(10'h010 + i));
      tick();
    end
    bus.out_ready = 1'b0;
    check("t3_empty_valid", 32'(bus.out_valid), 32'd0);

    // Steady state: one entry held, write and read every cycle
    write_one(10'h100);
    for (int k = 0; k < 20; k++) begin
      bus.in_data        = ADDR_W'(10'h101 + k);
      bus.data_available = 1'b1;
      bus.out_ready      = 1'b1;
      check("t4_addr",  32'(bus.out_addr), 32'(10'h100 + k));
      check("t4_count", 32'(bus.fifo_count), 32'd1);
      tick();
    end
    bus.data_available = 1'b0;
    bus.out_ready      = 1'b0;
    check("t4_last_addr",  32'(bus.out_addr), 32'h114);
    check("t4_last_count", 32'(bus.fifo_count), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t4_empty", 32'(bus.fifo_count), 32'd0);

    // Reset with entries held flushes everything
    for (int i = 0; i < 5; i++) write_one(ADDR_W'(10'h200 + i));
    check("t5_count", 32'(bus.fifo_count), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_valid", 32'(bus.out_valid), 32'd0);
    check("t5_count_rst", 32'(bus.fifo_count), 32'd0);
    check("t5_req",   32'(bus.data_required), 32'd1);
    check("t5_addr",  32'(bus.out_addr), 32'd0);
    write_one(10'h055);
    check("t5_post_addr",  32'(bus.out_addr), 32'h055);
    check("t5_post_count", 32'(bus.fifo_count), 32'd1);

`ifdef AER_IN_TIMESTAMP_EN
    // Timestamps across the counter wrap: counter is 0 after the reset edge,
    // so a write on the k-th following edge stores k-1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_ts_rst", 32'(bus.out_ts), 32'd0);
    for (int i = 0; i < 14; i++) tick();
    write_one(10'h0AA);
    tick();
    tick();
    write_one(10'h0BB);
    check("t6_addr0", 32'(bus.out_addr), 32'h0AA);
    check("t6_ts0",   32'(bus.out_ts), 32'd14);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t6_addr1", 32'(bus.out_addr), 32'h0BB);
    check("t6_ts1",   32'(bus.out_ts), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
